// File: rtl/nonrestoring_divider_pkg.sv
// Shared types and constants for the byte-serial non-restoring divider.
// Latency: n/a (types, constants and the state-to-control decode only).
// Backpressure: n/a.
package divider_pkg;

    localparam int WIDTH      = 8;
    localparam int ITERATIONS = 8;
    localparam int COUNT_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        LD_Q,
        LD_M,
        ITER,
        CORRECT,
        OUT_Q,
        OUT_R
    } state_t;

    // One bit per datapath action; the active bit follows the current state.
    typedef struct packed {
        logic ld_a;    // armed in IDLE, A loads only when enable is also high
        logic ld_q;
        logic ld_m;
        logic iter;
        logic corr;
        logic out_q;
        logic out_r;
        logic cnt_en;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            IDLE:    c.ld_a  = 1'b1;
            LD_Q:    c.ld_q  = 1'b1;
            LD_M:    c.ld_m  = 1'b1;
            ITER: begin
                c.iter   = 1'b1;
                c.cnt_en = 1'b1;
            end
            CORRECT: c.corr  = 1'b1;
            OUT_Q:   c.out_q = 1'b1;
            OUT_R:   c.out_r = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nonrestoring_divider_cu.sv
// Control FSM for the non-restoring divider: sequences load, iterate, correct, output.
// Latency: control vector is registered and tracks the state entered on each edge.
// Backpressure: none; enable is only looked at in IDLE.
module cu_nonrestoring
    import divider_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  enable_i,
    input  logic  count_last_i,
    input  logic  a_sign_i,
    input  logic  ovf_i,
    output ctrl_t ctrl_o,
    output logic  corr_add_o
);

    state_t state_q;
    ctrl_t  ctrl_q;

    // State register and registered control vector, updated together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ctrl_q  <= ctrl_of(IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= LD_Q;
                        ctrl_q  <= ctrl_of(LD_Q);
                    end
                end
                LD_Q: begin
                    state_q <= LD_M;
                    ctrl_q  <= ctrl_of(LD_M);
                end
                LD_M: begin
                    // An out-of-range divide skips straight to the result phase
                    if (ovf_i) begin
                        state_q <= OUT_Q;
                        ctrl_q  <= ctrl_of(OUT_Q);
                    end else begin
                        state_q <= ITER;
                        ctrl_q  <= ctrl_of(ITER);
                    end
                end
                ITER: begin
                    if (count_last_i) begin
                        state_q <= CORRECT;
                        ctrl_q  <= ctrl_of(CORRECT);
                    end
                end
                CORRECT: begin
                    state_q <= OUT_Q;
                    ctrl_q  <= ctrl_of(OUT_Q);
                end
                OUT_Q: begin
                    state_q <= OUT_R;
                    ctrl_q  <= ctrl_of(OUT_R);
                end
                OUT_R: begin
                    state_q <= IDLE;
                    ctrl_q  <= ctrl_of(IDLE);
                end
                default: begin
                    state_q <= IDLE;
                    ctrl_q  <= ctrl_of(IDLE);
                end
            endcase
        end
    end

    assign ctrl_o     = ctrl_q;
    // A negative partial remainder after the last step needs M added back
    assign corr_add_o = ctrl_q.corr & a_sign_i;

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned 2W/W non-restoring divider; operands in and results out byte-serially.
// Latency: enable edge 0 -> quotient after edge 11, remainder after edge 12 (2/3 on overflow).
// Backpressure: none; enable outside IDLE is dropped. Option macro: DIVIDER_OVF_CHECK_EN.
module nonrestoring_divider #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] inbus,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] outbus
);
    import divider_pkg::*;

    ctrl_t              ctrl;
    logic               corr_add;
    logic [WIDTH:0]     a_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   m_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [WIDTH:0]     shift_d;
    logic [WIDTH:0]     a_iter_d;
    logic [WIDTH:0]     a_corr_d;
    logic               count_last;
    logic               ovf;
    logic               done_q;
    logic [WIDTH-1:0]   outbus_q;

    // Shift A:Q left by one, then subtract or add M depending on the sign of A
    assign shift_d    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign a_iter_d   = a_q[WIDTH] ? (shift_d + {1'b0, m_q}) : (shift_d - {1'b0, m_q});
    assign a_corr_d   = a_q + {1'b0, m_q};
    assign count_last = (cnt_q == COUNT_W'(ITERATIONS - 1));

`ifdef DIVIDER_OVF_CHECK_EN
    logic err_q;
    // Quotient cannot fit in WIDTH bits unless the dividend high byte is below the divisor
    assign ovf = (inbus == '0) || (a_q[WIDTH-1:0] >= inbus);
    assign err = err_q;
`else
    assign ovf = 1'b0;
    assign err = 1'b0;
`endif

    cu_nonrestoring u_cu (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .count_last_i (count_last),
        .a_sign_i     (a_q[WIDTH]),
        .ovf_i        (ovf),
        .ctrl_o       (ctrl),
        .corr_add_o   (corr_add)
    );

    // Operand capture, one non-restoring step per ITER cycle, final remainder fix-up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            if (ctrl.ld_a && enable) a_q <= {1'b0, inbus};
            if (ctrl.ld_q)           q_q <= inbus;
            if (ctrl.ld_m)           m_q <= inbus;
            if (ctrl.iter) begin
                a_q <= a_iter_d;
                q_q <= {q_q[WIDTH-2:0], ~a_iter_d[WIDTH]};
            end
            if (corr_add)            a_q <= a_corr_d;
        end
    end

    // Iteration counter: cleared when the divisor loads, counts ITER cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ctrl.ld_m) begin
            cnt_q <= '0;
        end else if (ctrl.cnt_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef DIVIDER_OVF_CHECK_EN
    // Result bus registers: quotient, then remainder; forced FF/00 with err on overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            outbus_q <= '0;
            err_q    <= 1'b0;
        end else if (ctrl.ld_m && ovf) begin
            done_q   <= 1'b1;
            outbus_q <= '1;
            err_q    <= 1'b1;
        end else if (ctrl.corr) begin
            done_q   <= 1'b1;
            outbus_q <= q_q;
        end else if (ctrl.out_q) begin
            outbus_q <= err_q ? '0 : a_q[WIDTH-1:0];
        end else if (ctrl.out_r) begin
            done_q   <= 1'b0;
            outbus_q <= '0;
            err_q    <= 1'b0;
        end
    end
`else
    // Result bus registers: quotient during OUT_Q, remainder during OUT_R, zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            outbus_q <= '0;
        end else if (ctrl.corr) begin
            done_q   <= 1'b1;
            outbus_q <= q_q;
        end else if (ctrl.out_q) begin
            outbus_q <= a_q[WIDTH-1:0];
        end else if (ctrl.out_r) begin
            done_q   <= 1'b0;
            outbus_q <= '0;
        end
    end
`endif

    assign done   = done_q;
    assign outbus = outbus_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider with an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_nonrestoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] inbus;
    logic       done;
    logic       err;
    logic [7:0] outbus;

`ifdef DIVIDER_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam logic [7:0] DIV0_REM = OVF_EN ? 8'h00 : 8'h34;

    nonrestoring_divider #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .inbus  (inbus),
        .done   (done),
        .err    (err),
        .outbus (outbus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectation of the operation in flight (t0 = edge that sampled enable)
    bit         exp_act = 1'b0;
    int         exp_t0  = 0;
    int         exp_lat = 11;
    logic [7:0] exp_q   = 8'h00;
    logic [7:0] exp_r   = 8'h00;
    bit         exp_err = 1'b0;
    bit         exp_chk = 1'b1;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    // Division by plain arithmetic, with the out-of-range rules layered on top
    task automatic model(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r, output bit e,
                         output bit chk, output int lat);
        int dividend;
        dividend = {16'd0, hi, lo};
        q = 8'h00; r = 8'h00; e = 1'b0; chk = 1'b1; lat = 11;
        if (OVF_EN && (dv == 8'h00 || hi >= dv)) begin
            q = 8'hFF; r = 8'h00; e = 1'b1; lat = 2;
        end else if (dv == 8'h00) begin
            q = 8'hFF; r = lo;
        end else if (hi >= dv) begin
            chk = 1'b0;
        end else begin
            q = 8'(dividend / int'(dv));
            r = 8'(dividend % int'(dv));
        end
    endtask

    // Per-cycle comparison of all outputs against the model schedule
    always @(negedge clk) begin
        int         k;
        logic       e_done;
        logic       e_err;
        logic [7:0] e_out;
        k      = cyc - exp_t0;
        e_done = exp_act && (k == exp_lat || k == exp_lat + 1);
        e_err  = e_done && exp_err;
        e_out  = !e_done ? 8'h00 : ((k == exp_lat) ? exp_q : exp_r);
        check("done", {7'd0, done}, {7'd0, e_done});
        check("err", {7'd0, err}, {7'd0, e_err});
        if (!e_done || exp_chk) check("outbus", outbus, e_out);
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_act = 1'b0;
        #1;
        check("async_rst_done", {7'd0, done}, 8'h00);
        check("async_rst_err", {7'd0, err}, 8'h00);
        check("async_rst_outbus", outbus, 8'h00);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // One operation; pin = compare against hand values, poke = pulse enable in ITER,
    // abort = reset when cyc reaches t0+abort
    task automatic run_op(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                          input bit pin, input logic [7:0] lq, input logic [7:0] lr,
                          input bit poke, input int abort);
        logic [7:0] q;
        logic [7:0] r;
        bit         e;
        bit         c;
        int         lat;
        model(hi, lo, dv, q, r, e, c, lat);
        @(posedge clk); #2;
        exp_q = q; exp_r = r; exp_err = e; exp_chk = c; exp_lat = lat;
        exp_t0 = cyc + 1; exp_act = 1'b1;
        enable = 1'b1; inbus = hi;
        @(posedge clk); #2;
        enable = 1'b0; inbus = lo;
        @(posedge clk); #2;
        inbus = dv;
        @(posedge clk); #2;
        inbus = 8'hA5;
        for (int i = 2; i < lat; i++) begin
            if (abort == i) begin
                do_reset();
                return;
            end
            @(posedge clk); #2;
            if (poke && i == 4) enable = 1'b1;
            if (poke && i == 7) enable = 1'b0;
        end
        if (abort == lat) begin
            check("pre_rst_done", {7'd0, done}, 8'h01);
            do_reset();
            return;
        end
        if (pin) begin
            check("quot_done", {7'd0, done}, 8'h01);
            check("quotient", outbus, lq);
        end
        @(posedge clk); #2;
        if (pin) begin
            check("rem_done", {7'd0, done}, 8'h01);
            check("remainder", outbus, lr);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; inbus = 8'h00;
        #1;
        check("reset_done", {7'd0, done}, 8'h00);
        check("reset_err", {7'd0, err}, 8'h00);
        check("reset_outbus", outbus, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        run_op(8'h03, 8'hE8, 8'h07, 1'b1, 8'h8E, 8'h06, 1'b0, -1);   // 1000 / 7
        run_op(8'h7F, 8'hFF, 8'hFF, 1'b1, 8'h80, 8'h7F, 1'b0, -1);   // 32767 / 255
        run_op(8'hFE, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFE, 1'b0, -1);   // largest valid quotient
        run_op(8'h12, 8'h34, 8'h56, 1'b1, 8'h36, 8'h10, 1'b0, -1);   // 4660 / 86
        run_op(8'h00, 8'h00, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0, -1);   // zero dividend
        run_op(8'h0A, 8'h00, 8'h05, OVF_EN, 8'hFF, 8'h00, 1'b0, -1); // overflow
        run_op(8'h05, 8'h00, 8'h05, OVF_EN, 8'hFF, 8'h00, 1'b0, -1); // high byte == divisor
        run_op(8'h00, 8'h34, 8'h00, 1'b1, 8'hFF, DIV0_REM, 1'b0, -1); // divide by zero
        run_op(8'h03, 8'hE8, 8'h07, 1'b1, 8'h8E, 8'h06, 1'b1, -1);   // enable pulsed in ITER
        repeat (20) @(posedge clk);                                   // no stray second run
        run_op(8'h03, 8'hE8, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 6);    // reset during ITER
        run_op(8'h00, 8'h64, 8'h0A, 1'b1, 8'h0A, 8'h00, 1'b0, -1);   // 100 / 10 after reset
        run_op(8'h03, 8'hE8, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 11);   // reset while done high
        run_op(8'h00, 8'h64, 8'h0A, 1'b1, 8'h0A, 8'h00, 1'b0, -1);
        repeat (16) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
